// File: rtl/alu_pkg.sv
// Shared ALU shift-path constants: operand geometry, shift-kind codes and
// the iterative shifter FSM state encoding.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/iter_shift_ctrl_if.sv
// Request/response bundle between the ALU control FSM (master) and the
// iterative shift unit (slave).
interface iter_shift_ctrl_if;
  import alu_pkg::*;

  // Handshake: start is taken only while busy=0; once taken, busy stays high
  // until the done cycle inclusive. done pulses for one cycle with result
  // valid, and result then holds until the next accepted start. abort
  // cancels an operation in flight without a done pulse.
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] shamt;
  logic               abort;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  shift_state_t       dbg_state;

  modport master (
    output start, op, data, shamt, abort,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  start, op, data, shamt, abort,
    output busy, done, result, dbg_state
  );

endinterface

// File: rtl/shift_step1.sv
// One-bit-per-call shifter: produces a single shift/rotate step of word.
module shift_step1
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] stepped
);

  always_comb begin
    stepped = word;
    case (op)
      SHIFT_SLL: stepped = {word[WIDTH-2:0], 1'b0};
      SHIFT_SRL: stepped = {1'b0, word[WIDTH-1:1]};
      SHIFT_SRA: stepped = {word[WIDTH-1], word[WIDTH-1:1]};
      SHIFT_ROR: stepped = {word[0], word[WIDTH-1:1]};
      default:   stepped = word;
    endcase
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Iterative shift controller: latches an operand and applies one shift step
// per cycle until the requested amount is consumed.
module iter_shift_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  iter_shift_ctrl_if.slave bus
);

  shift_state_t       state, state_nx;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_step;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         op_q;
  logic               accept;

  assign accept = (state == ST_IDLE) && bus.start;

  shift_step1 u_step (
    .word    (work),
    .op      (op_q),
    .stepped (work_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nx = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (bus.abort)                      state_nx = ST_IDLE;
        else if (count == SHAMT_W'(1))      state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // On abort the working register is simply frozen; its value is not meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      count <= '0;
      op_q  <= SHIFT_SLL;
    end else if (accept) begin
      work  <= bus.data;
      op_q  <= bus.op;
      count <= bus.shamt;
    end else if ((state == ST_SHIFT) && !bus.abort) begin
      work  <= work_step;
      count <= count - SHAMT_W'(1);
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE) && !bus.abort;
  assign bus.result    = work;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl: latency, results per shift kind,
// ignored starts, abort and mid-operation reset.
module tb_iter_shift_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [31:0] exp_q[$];

  iter_shift_ctrl_if ifc();

  iter_shift_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  // Accept one operation and follow it to done; ab drives abort alongside start.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] expv, input logic ab);
    int n;
    logic [31:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = o; ifc.data = d; ifc.shamt = s; ifc.abort = ab;
    @(negedge clk);
    ifc.start = 1'b0; ifc.data = '0; ifc.abort = 1'b0;
    n = 1;
    while (!ifc.done && n < 40) begin
      check({tag, "_busy"}, 32'(ifc.busy), 32'd1);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(s) + 32'd1);
    check({tag, "_busy_at_done"}, 32'(ifc.busy), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_result"}, ifc.result, e);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(ifc.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(ifc.done), 32'd0);
    check({tag, "_hold"}, ifc.result, e);
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int first;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.op = 2'b00; ifc.data = '0; ifc.shamt = '0; ifc.abort = 1'b0;
    wait_cycles(2);
    check("rst_busy",   32'(ifc.busy), 32'd0);
    check("rst_done",   32'(ifc.done), 32'd0);
    check("rst_result", ifc.result, 32'h0);
    check("rst_state",  32'(ifc.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_cycles(1);

    // abort in IDLE has no effect
    ifc.abort = 1'b1;
    wait_cycles(1);
    ifc.abort = 1'b0;
    check("idle_abort_busy", 32'(ifc.busy), 32'd0);

    do_op("srl4",   SHIFT_SRL, 32'h8000_0001, 5'd4,  32'h0800_0000, 1'b0);
    do_op("sra31",  SHIFT_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    do_op("srl31",  SHIFT_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    do_op("sll0",   SHIFT_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
    do_op("sll8",   SHIFT_SLL, 32'h1234_5678, 5'd8,  32'h3456_7800, 1'b0);
    do_op("ror1",   SHIFT_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0);
    do_op("ror4",   SHIFT_ROR, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0);
    do_op("ror8",   SHIFT_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0);
    do_op("sra_pos",SHIFT_SRA, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, 1'b0);
    do_op("start_beats_abort", SHIFT_SLL, 32'h0000_0001, 5'd3, 32'h0000_0008, 1'b1);

    // Second start while busy must be ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = SHIFT_SRL; ifc.data = 32'h0000_0100; ifc.shamt = 5'd8;
    @(negedge clk);                       // cycle 1
    ifc.start = 1'b0;
    @(negedge clk);                       // cycle 2
    ifc.start = 1'b1; ifc.op = SHIFT_SLL; ifc.data = 32'hFFFF_FFFF; ifc.shamt = 5'd3;
    @(negedge clk);                       // cycle 3
    ifc.start = 1'b0;
    pulses = 0;
    first = 0;
    for (int n = 3; n < 25; n++) begin
      if (ifc.done) begin
        pulses++;
        if (first == 0) begin
          first = n;
          check("ign_result", ifc.result, 32'h0000_0001);
        end
      end
      @(negedge clk);
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_latency", 32'(first), 32'd9);

    // start in the DONE cycle is ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = SHIFT_SLL; ifc.data = 32'h0000_0001; ifc.shamt = 5'd1;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    check("dstart_done", 32'(ifc.done), 32'd1);
    ifc.start = 1'b1; ifc.data = 32'hDEAD_BEEF; ifc.shamt = 5'd2;
    @(negedge clk);
    ifc.start = 1'b0;
    check("dstart_busy", 32'(ifc.busy), 32'd0);
    check("dstart_result", ifc.result, 32'h0000_0002);

    // abort at SHIFT cycle 3 of a 10-step shift
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = SHIFT_SLL; ifc.data = 32'h0000_0001; ifc.shamt = 5'd10;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_cycles(2);                       // now in cycle 3
    check("abrt_state", 32'(ifc.dbg_state), 32'(ST_SHIFT));
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    check("abrt_busy", 32'(ifc.busy), 32'd0);
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      if (ifc.done || ifc.busy) pulses++;
      @(negedge clk);
    end
    check("abrt_quiet", 32'(pulses), 32'd0);

    // abort in the DONE cycle suppresses done
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = SHIFT_SRL; ifc.data = 32'h0000_00F0; ifc.shamt = 5'd2;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_cycles(2);                       // cycle 3 is the DONE state
    ifc.abort = 1'b1;
    #1;
    check("dabrt_state", 32'(ifc.dbg_state), 32'(ST_DONE));
    check("dabrt_done", 32'(ifc.done), 32'd0);
    @(negedge clk);
    ifc.abort = 1'b0;
    check("dabrt_busy", 32'(ifc.busy), 32'd0);

    // reset in the middle of a shift
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = SHIFT_SLL; ifc.data = 32'h0000_0003; ifc.shamt = 5'd10;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_cycles(2);
    rst_n = 1'b0;
    #1;
    check("mrst_busy",   32'(ifc.busy), 32'd0);
    check("mrst_done",   32'(ifc.done), 32'd0);
    check("mrst_result", ifc.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", SHIFT_SRL, 32'hA000_0000, 5'd5, 32'h0500_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iter_shift_ctrl.md
Name: iter_shift_ctrl

Overview:
Multi-cycle shift unit controller for the ALU shift path. It accepts a 32-bit operand, a shift amount and a shift kind, then drives a 1-bit-per-cycle shift step until the amount is exhausted. It exposes a start/busy/done handshake to the ALU control FSM. It replaces a full barrel shifter where area matters.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
op  input  2  shift kind: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
data  input  WIDTH  operand; captured on accepted start
shamt  input  SHAMT_W  shift amount; captured on accepted start
abort  input  1  synchronous cancel of an in-flight operation
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse; result valid on that cycle
result  output  WIDTH  shifted value; held stable from done until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, internal count=0, op register=00.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 is an accept. On that edge: latch data into the working register (drives result), latch op, and set count=shamt. Next state is SHIFT if shamt!=0, else DONE.
- SHIFT: each cycle the working register is replaced by one step of the selected op:
  - SLL: {w[W-2:0],0}
  - SRL: {0,w[W-1:1]}
  - SRA: {w[W-1],w[W-1:1]}
  - ROR: {w[0],w[W-1:1]}
  - count decrements by 1. When count==1 before the edge, next state is DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE.
- Latency: done is high shamt+1 cycles after the accept edge. shamt=0 gives done 1 cycle after accept, with result equal to data.
- start while busy=1 is ignored and not queued. start in the DONE cycle is also ignored.
- abort=1 in SHIFT or DONE: next state is IDLE and done is not asserted that cycle. The working register keeps its partial value and is undefined for software. abort in IDLE has no effect. If abort and start arrive together in IDLE, start wins.
- Rotate wraps modulo WIDTH. shamt is always < WIDTH, so no saturation is needed.
- Mid-operation reset aborts immediately and applies the reset values above.
- result is a direct register output with no combinational path from inputs.

Decomposition:
- Shared package (alu_pkg): op encodings SHIFT_SLL/SRL/SRA/ROR as 2-bit localparams, FSM state encodings, and WIDTH=32 / SHAMT_W=5 constants.
- Sub-module shift_step1: purely combinational single-bit shifter (inputs: word, op; output: stepped word), instantiated once.
- iter_shift_ctrl contains the FSM, counter and working register.

Test Plan:
- SRL, data=0x80000001, shamt=4, start pulse → busy high for 5 cycles, done at cycle 5, result=0x08000000.
- SRA, data=0x80000000, shamt=31 → done at cycle 32, result=0xFFFFFFFF. Repeat with SRL → result=0x00000001.
- SLL, data=0x12345678, shamt=0 → done 1 cycle after accept, result=0x12345678. Then SLL with shamt=8 → result=0x34567800.
- ROR, data=0x00000001, shamt=1 → result=0x80000000. ROR with data=0xF0000000, shamt=4 → result=0x0F000000.
- Second start with data=0xFFFFFFFF, issued 2 cycles into an SRL of 0x00000100 by 8 → ignored; result=0x00000001, a single done pulse.
- abort at SHIFT cycle 3 of a 10-bit shift → no done and busy drops next cycle. Separately, rst_n low mid-SHIFT → busy=0, done=0, result=0 immediately, then a new start completes normally.
